apb_slave_regfile: RTL and testbench
====================================

// Module: apb_slave_regfile
// PURPOSE
//  APB completer holding DEPTH 8-bit registers; answers transfers from the APB master on the same pclk.
//  Inserts WAIT_STATES programmable wait cycles via pready; flags out-of-range addresses on pslverr.
//  Sits at the far end of the master's psel/penable/pwrite/paddr/pwdata bus; returns prdata/pready/pslverr.
// PARAMETERS
//  DEPTH        16  number of 8-bit registers, addresses 0..DEPTH-1 (DEPTH <= 256)
//  WAIT_STATES  0   cycles pready is held low in ACCESS before completion (0..15)
// PORTS
//  pclk     in   1  clock, all state on rising edge
//  prst     in   1  reset, asynchronous, active-low
//  psel     in   1  slave select from master
//  penable  in   1  access-phase strobe from master
//  pwrite   in   1  1 = write, 0 = read
//  paddr    in   8  register address
//  pwdata   in   8  write data
//  prdata   out  8  read data, valid only while pready=1 on a read
//  pready   out  1  transfer completes in a cycle with psel & penable & pready
//  pslverr  out  1  error response, valid only while pready=1
// BEHAVIOUR
//  Reset (prst=0, async): state=IDLE, wait counter=0, all registers=8'h00.
//   prdata=0, pready=0, pslverr=0.
//  FSM states (encoded in package): IDLE, SETUP, ACCESS.
//   IDLE  : psel & !penable -> SETUP; capture paddr, pwrite, pwdata; cnt<=WAIT_STATES. Otherwise stay.
//   SETUP : psel & penable -> ACCESS. psel=0 -> IDLE (abort). psel & !penable -> stay; recapture.
//   ACCESS: pready = (cnt==0). While cnt!=0 and psel & penable: cnt<=cnt-1, stay.
//    Completion cycle (psel & penable & pready): commit, then back-to-back check.
//    Back-to-back: psel & !penable on the next cycle is a new SETUP, handled exactly as in IDLE.
//    psel or penable dropped before completion -> IDLE, no write, no response.
//  Outputs are decoded from registered state/cnt/captured fields; zero-wait gives 2-cycle transfer (SETUP+ACCESS).
//  Write commit: on completion edge, reg[addr_q] <= wdata_q, only if addr_q < DEPTH.
//  Read: prdata = reg[addr_q] when pready & !pwrite_q & addr_q<DEPTH, else 8'h00.
//  Error: addr_q >= DEPTH -> pslverr=1 together with pready; write suppressed; prdata=0.
//  pslverr=0 and prdata=0 in every cycle where pready=0.
//  Signals sampled in ACCESS are the captured ones; mid-access changes to paddr/pwdata/pwrite are ignored.
//  Read and write of same register in consecutive transfers: read returns newly written value (no hazard).
//  Reset asserted mid-transfer: immediate return to IDLE; registers cleared; in-flight write lost.
//  Counter width 4 bits; WAIT_STATES>15 is illegal (elaboration check).
// STRUCTURE
//  Package apb_pkg: APB_AW=8, APB_DW=8, state localparams IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
//   Same package is shared with the master.
//  Sub-module apb_reg_array: DEPTH x 8 storage.
//   Async-reset clear, one synchronous write port (we, waddr, wdata), one combinational read port.
//  Top holds FSM, wait counter, capture registers, address-range check, output decode.
// TESTING
//  1 Reset: hold prst=0 3 cycles -> pready=0, pslverr=0, prdata=0; then read addr 5 -> prdata=8'h00.
//  2 Zero-wait write 8'hA5 to addr 3, then read addr 3 -> each transfer 2 cycles, pready=1 in ACCESS.
//    Read returns 8'hA5, pslverr=0.
//  3 WAIT_STATES=2: write addr 1 -> pready low 2 ACCESS cycles, high on 3rd; write lands on that edge only.
//  4 Write 8'h3C to addr 16 (DEPTH=16) -> pready=1 with pslverr=1; register 0 unchanged; read addr 16 -> prdata=0, pslverr=1.
//  5 Abort: SETUP for write addr 2, drop psel in ACCESS with WAIT_STATES=2 -> FSM IDLE, reg[2] unchanged.
//    Then back-to-back writes addr 4/5 with no IDLE between -> both committed.
//  6 Reset mid-ACCESS on write 8'hFF to addr 7 -> outputs 0 immediately; subsequent read addr 7 -> 8'h00.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, wait-counter width and the completer FSM encoding.
// Used by both the master and the completer side of the bus.
package apb_pkg;

  localparam int APB_AW = 8;
  localparam int APB_DW = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_reg_array.sv
// DEPTH x 8-bit register storage: async clear, one synchronous write port, one combinational read port.
module apb_reg_array
  import apb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [APB_AW-1:0] waddr_i,
  input  logic [APB_DW-1:0] wdata_i,
  input  logic [APB_AW-1:0] raddr_i,
  output logic [APB_DW-1:0] rdata_o
);

  logic [APB_DW-1:0] mem_q [DEPTH];

  // Full-address compare per entry, so addresses beyond DEPTH never alias onto a register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr_i == APB_AW'(i)) mem_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_i == APB_AW'(i)) rdata_o = mem_q[i];
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with DEPTH 8-bit registers, programmable wait states and out-of-range error response.
// SETUP/ACCESS mean "a setup has been captured"; pready is decoded from registered state and counter.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_AW-1:0] paddr,
  input  logic [APB_DW-1:0] pwdata,
  output logic [APB_DW-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  if (DEPTH < 1 || DEPTH > 256) begin : g_bad_depth
    $error("apb_slave_regfile: DEPTH must be in 1..256");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("apb_slave_regfile: WAIT_STATES must be in 0..15");
  end

  localparam int                 AWP      = APB_AW + 1;
  localparam logic [CNT_W-1:0]  WAIT_CNT = CNT_W'(WAIT_STATES);
  localparam logic [APB_AW:0]   DEPTH_L  = AWP'(DEPTH);

  apb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [APB_AW-1:0] addr_q;
  logic              wr_q;
  logic [APB_DW-1:0] wdata_q;

  logic              busy;
  logic              ready;
  logic              in_range;
  logic              capture;
  logic              access;
  logic              we;
  logic [APB_DW-1:0] rdata;

  assign busy     = (state_q == SETUP) || (state_q == ACCESS);
  assign ready    = busy && (cnt_q == '0);
  assign in_range = {1'b0, addr_q} < DEPTH_L;
  assign capture  = ((state_q == IDLE) || (state_q == SETUP)) && psel && !penable;
  assign access   = psel && penable;
  assign we       = ready && access && wr_q && in_range;

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      if (capture) begin
        addr_q  <= paddr;
        wr_q    <= pwrite;
        wdata_q <= pwdata;
        cnt_q   <= WAIT_CNT;
      end else if (busy && access && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      // Completion returns to IDLE; a back-to-back setup on the next cycle is captured from there.
      case (state_q)
        IDLE: begin
          if (capture) state_q <= SETUP;
        end
        SETUP: begin
          if (!psel)        state_q <= IDLE;
          else if (penable) state_q <= (cnt_q == '0) ? IDLE : ACCESS;
        end
        ACCESS: begin
          if (!access || (cnt_q == '0)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  apb_reg_array #(
    .DEPTH (DEPTH)
  ) u_regs (
    .clk_i   (pclk),
    .rst_ni  (prst),
    .we_i    (we),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (addr_q),
    .rdata_o (rdata)
  );

  assign pready  = ready;
  assign pslverr = ready && !in_range;
  assign prdata  = (ready && !wr_q && in_range) ? rdata : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: a zero-wait and a two-wait instance, each checked every cycle against
// a transaction-level model (register array plus expected pready/prdata/pslverr per bus cycle).
module tb_apb_slave_regfile;

  logic       clk;
  logic       prst;
  logic       psel    [2];
  logic       penable [2];
  logic       pwrite  [2];
  logic [7:0] paddr   [2];
  logic [7:0] pwdata  [2];
  logic [7:0] prdata  [2];
  logic       pready  [2];
  logic       pslverr [2];

  logic       exp_valid  [2];
  logic       exp_pready [2];
  logic [7:0] exp_prdata [2];
  logic       exp_pslverr[2];
  logic [7:0] mem_m [2][256];

  int tests;
  int fails;

  apb_slave_regfile #(.DEPTH(16), .WAIT_STATES(0)) dut0 (
    .pclk(clk), .prst(prst), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
  );

  apb_slave_regfile #(.DEPTH(16), .WAIT_STATES(2)) dut2 (
    .pclk(clk), .prst(prst), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<500000", $time);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (exp_valid[b]) begin
        tests++;
        if (pready[b] !== exp_pready[b] || prdata[b] !== exp_prdata[b] || pslverr[b] !== exp_pslverr[b]) begin
          fails++;
          $display("FAIL bus%0d_cycle t=%0t: got pready=%b prdata=%h pslverr=%b, want pready=%b prdata=%h pslverr=%b",
                   b, $time, pready[b], prdata[b], pslverr[b], exp_pready[b], exp_prdata[b], exp_pslverr[b]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, expv);
    end
  endtask

  task automatic set_exp(input int b, input logic r, input logic [7:0] d, input logic e);
    exp_pready[b]  = r;
    exp_prdata[b]  = d;
    exp_pslverr[b] = e;
  endtask

  task automatic clear_model();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 256; i++) mem_m[b][i] = 8'h00;
  endtask

  task automatic idle(input int b, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      psel[b] = 1'b0;
      penable[b] = 1'b0;
      set_exp(b, 1'b0, 8'h00, 1'b0);
    end
  endtask

  // One APB transfer on bus b. abort_k >= 0 drops psel in that access cycle (only before pready).
  task automatic xfer(input int b, input logic wr, input logic [7:0] a, input logic [7:0] d,
                      input int abort_k, input logic gap,
                      output logic [7:0] rd, output logic er, output int nlow);
    int   w;
    logic inr;
    w   = (b == 0) ? 0 : 2;
    inr = (a < 8'd16);
    rd = 8'h00; er = 1'b0; nlow = 0;
    @(posedge clk); #1;
    psel[b] = 1'b1; penable[b] = 1'b0; pwrite[b] = wr; paddr[b] = a; pwdata[b] = d;
    set_exp(b, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k <= w; k++) begin
      @(posedge clk); #1;
      if (k == abort_k) begin
        psel[b] = 1'b0; penable[b] = 1'b0;
        set_exp(b, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        return;
      end
      penable[b] = 1'b1;
      if (k > 0) begin
        paddr[b] = 8'($urandom); pwdata[b] = 8'($urandom); pwrite[b] = 1'($urandom);
      end
      if (k == w) set_exp(b, 1'b1, (!wr && inr) ? mem_m[b][a] : 8'h00, !inr);
      else        set_exp(b, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      if (pready[b] !== 1'b1) nlow++;
      if (k == w) begin rd = prdata[b]; er = pslverr[b]; end
    end
    if (wr && inr) mem_m[b][a] = d;
    if (gap) idle(b, 1);
  endtask

  logic [7:0] rd;
  logic       er;
  int         nlow;

  initial begin
    tests = 0; fails = 0;
    clear_model();
    prst = 1'b0;
    for (int b = 0; b < 2; b++) begin
      psel[b] = 1'b0; penable[b] = 1'b0; pwrite[b] = 1'b0; paddr[b] = 8'h00; pwdata[b] = 8'h00;
      exp_valid[b] = 1'b1;
      set_exp(b, 1'b0, 8'h00, 1'b0);
    end

    // Reset held three cycles, then reads of a cleared register
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready0", 32'(pready[0]), 32'd0);
    chk("rst_pready1", 32'(pready[1]), 32'd0);
    chk("rst_prdata0", 32'(prdata[0]), 32'd0);
    chk("rst_pslverr1", 32'(pslverr[1]), 32'd0);
    prst = 1'b1;
    idle(0, 1);
    xfer(0, 1'b0, 8'd5, 8'h00, -1, 1'b1, rd, er, nlow);
    chk("rst_read5_bus0", 32'(rd), 32'h00);
    xfer(1, 1'b0, 8'd5, 8'h00, -1, 1'b1, rd, er, nlow);
    chk("rst_read5_bus1", 32'(rd), 32'h00);

    // Zero-wait write then read back
    xfer(0, 1'b1, 8'd3, 8'hA5, -1, 1'b0, rd, er, nlow);
    chk("zw_write_nlow", 32'(nlow), 32'd0);
    xfer(0, 1'b0, 8'd3, 8'h00, -1, 1'b1, rd, er, nlow);
    chk("zw_read_data", 32'(rd), 32'hA5);
    chk("zw_read_err", 32'(er), 32'd0);
    chk("zw_read_nlow", 32'(nlow), 32'd0);

    // Two wait states
    xfer(1, 1'b1, 8'd1, 8'h5A, -1, 1'b1, rd, er, nlow);
    chk("ws2_write_nlow", 32'(nlow), 32'd2);
    xfer(1, 1'b0, 8'd1, 8'h00, -1, 1'b1, rd, er, nlow);
    chk("ws2_read_data", 32'(rd), 32'h5A);

    // Out-of-range address
    xfer(0, 1'b1, 8'd16, 8'h3C, -1, 1'b1, rd, er, nlow);
    chk("oor_write_err", 32'(er), 32'd1);
    xfer(0, 1'b0, 8'd0, 8'h00, -1, 1'b1, rd, er, nlow);
    chk("oor_reg0_data", 32'(rd), 32'h00);
    xfer(0, 1'b0, 8'd16, 8'h00, -1, 1'b1, rd, er, nlow);
    chk("oor_read_data", 32'(rd), 32'h00);
    chk("oor_read_err", 32'(er), 32'd1);

    // Abort during wait states, then back-to-back writes
    xfer(1, 1'b1, 8'd2, 8'h77, 1, 1'b0, rd, er, nlow);
    idle(1, 1);
    xfer(1, 1'b0, 8'd2, 8'h00, -1, 1'b1, rd, er, nlow);
    chk("abort_reg2", 32'(rd), 32'h00);
    xfer(1, 1'b1, 8'd4, 8'h44, -1, 1'b0, rd, er, nlow);
    xfer(1, 1'b1, 8'd5, 8'h55, -1, 1'b0, rd, er, nlow);
    xfer(1, 1'b0, 8'd4, 8'h00, -1, 1'b0, rd, er, nlow);
    chk("b2b_reg4", 32'(rd), 32'h44);
    xfer(1, 1'b0, 8'd5, 8'h00, -1, 1'b1, rd, er, nlow);
    chk("b2b_reg5", 32'(rd), 32'h55);

    // Reset in the middle of an access
    xfer(0, 1'b1, 8'd7, 8'h99, -1, 1'b1, rd, er, nlow);
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'd7; pwdata[0] = 8'hFF;
    set_exp(0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    penable[0] = 1'b1;
    exp_valid[0] = 1'b0;
    #1;
    chk("midrst_pready_before", 32'(pready[0]), 32'd1);
    #1;
    prst = 1'b0;
    #1;
    chk("midrst_pready", 32'(pready[0]), 32'd0);
    chk("midrst_prdata", 32'(prdata[0]), 32'd0);
    chk("midrst_pslverr", 32'(pslverr[0]), 32'd0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    set_exp(0, 1'b0, 8'h00, 1'b0);
    exp_valid[0] = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    prst = 1'b1;
    xfer(0, 1'b0, 8'd7, 8'h00, -1, 1'b1, rd, er, nlow);
    chk("midrst_reg7", 32'(rd), 32'h00);
    xfer(1, 1'b0, 8'd4, 8'h00, -1, 1'b1, rd, er, nlow);
    chk("midrst_bus1_reg4", 32'(rd), 32'h00);

    // Randomized traffic, checked cycle by cycle against the model
    begin
      int   prev_b;
      logic open;
      prev_b = 0;
      open   = 1'b0;
      for (int n = 0; n < 120; n++) begin
        int         b;
        int         ak;
        logic       wr;
        logic       gap;
        logic [7:0] a;
        logic [7:0] d;
        b   = int'($urandom_range(0, 1));
        wr  = 1'($urandom);
        a   = 8'($urandom_range(0, 19));
        d   = 8'($urandom);
        gap = ($urandom_range(0, 2) == 0);
        ak  = (b == 1 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, 1)) : -1;
        if (open && b != prev_b) idle(prev_b, 1);
        xfer(b, wr, a, d, ak, gap, rd, er, nlow);
        open   = !gap && (ak < 0);
        prev_b = b;
      end
      if (open) idle(prev_b, 1);
    end

    // Final sweep of every register on both buses
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) xfer(b, 1'b0, 8'(i), 8'h00, -1, 1'b0, rd, er, nlow);
      idle(b, 1);
    end

    idle(0, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
